// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Decode-to-execute pipeline register. It captures the decoded
//            instruction fields, selects the ALU operand sources, applies
//            EX/MEM and MEM/WB forwarding and stalls on load-use hazards.
//            Both sides use a valid/ready handshake.
// Options  : ID_EX_STALL_CNT_EN enables the 32-bit stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_src_a_pc,
    input  logic                  id_src_b_imm,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  exm_reg_write,
    input  logic                  exm_is_load,
    input  logic [REG_ADDR_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]       exm_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_result,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [3:0]            ex_alu_op,
    output logic [XLEN-1:0]       ex_operand_a,
    output logic [XLEN-1:0]       ex_operand_b,
    output logic [XLEN-1:0]       ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic [31:0]           stall_cycles
);

    localparam logic [REG_ADDR_W-1:0] C_X0 = '0;

    logic                  r_valid;
    logic [3:0]            r_alu_op;
    logic [XLEN-1:0]       r_pc;
    logic [REG_ADDR_W-1:0] r_rs1_addr;
    logic [REG_ADDR_W-1:0] r_rs2_addr;
    logic [XLEN-1:0]       r_rs1_data;
    logic [XLEN-1:0]       r_rs2_data;
    logic [XLEN-1:0]       r_imm;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;
    logic                  r_src_a_pc;
    logic                  r_src_b_imm;

    logic                  w_hazard;
    logic                  w_ex_valid;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_refresh_rs1;
    logic                  w_refresh_rs2;
    logic [XLEN-1:0]       w_fwd_rs1;
    logic [XLEN-1:0]       w_fwd_rs2;

    // A load in EX/MEM has no data yet, so a dependent held instruction waits.
    assign w_hazard = r_valid && exm_reg_write && exm_is_load && (exm_rd_addr != C_X0) &&
                      ((exm_rd_addr == r_rs1_addr) || (exm_rd_addr == r_rs2_addr));

    assign w_ex_valid = r_valid && !w_hazard;
    assign w_issue    = w_ex_valid && ex_ready;
    assign id_ready   = !r_valid || w_issue;
    assign w_accept   = id_valid && id_ready && !flush;

    // Keep the held operand current once its producer has retired from WB.
    assign w_refresh_rs1 = r_valid && !w_issue && wb_reg_write && (wb_rd_addr != C_X0) &&
                           (wb_rd_addr == r_rs1_addr);
    assign w_refresh_rs2 = r_valid && !w_issue && wb_reg_write && (wb_rd_addr != C_X0) &&
                           (wb_rd_addr == r_rs2_addr);

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exm_reg_write && !exm_is_load && (exm_rd_addr == r_rs1_addr) && (r_rs1_addr != C_X0))
            w_fwd_rs1 = exm_result;
        else if (wb_reg_write && (wb_rd_addr == r_rs1_addr) && (r_rs1_addr != C_X0))
            w_fwd_rs1 = wb_result;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (exm_reg_write && !exm_is_load && (exm_rd_addr == r_rs2_addr) && (r_rs2_addr != C_X0))
            w_fwd_rs2 = exm_result;
        else if (wb_reg_write && (wb_rd_addr == r_rs2_addr) && (r_rs2_addr != C_X0))
            w_fwd_rs2 = wb_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_valid <= 1'b0;
        else if (flush)
            r_valid <= 1'b0;
        else if (w_accept)
            r_valid <= 1'b1;
        else if (w_issue)
            r_valid <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op    <= '0;
            r_pc        <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_src_a_pc  <= 1'b0;
            r_src_b_imm <= 1'b0;
        end else if (w_accept) begin
            r_alu_op    <= id_alu_op;
            r_pc        <= id_pc;
            r_rs1_addr  <= id_rs1_addr;
            r_rs2_addr  <= id_rs2_addr;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
            r_imm       <= id_imm;
            r_rd_addr   <= id_rd_addr;
            r_reg_write <= id_reg_write;
            r_src_a_pc  <= id_src_a_pc;
            r_src_b_imm <= id_src_b_imm;
        end else begin
            if (w_refresh_rs1)
                r_rs1_data <= wb_result;
            if (w_refresh_rs2)
                r_rs2_data <= wb_result;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (r_valid && !w_issue && !flush)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

    assign ex_valid     = w_ex_valid;
    assign ex_alu_op    = r_alu_op;
    assign ex_pc        = r_pc;
    assign ex_rd_addr   = r_rd_addr;
    assign ex_reg_write = r_reg_write && w_ex_valid;
    assign ex_operand_a = r_src_a_pc  ? r_pc  : w_fwd_rs1;
    assign ex_operand_b = r_src_b_imm ? r_imm : w_fwd_rs2;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the execute-stage ALU.
- Captures decoded instruction fields and selects operand sources: rs1 or PC for A, rs2 or immediate for B.
- Applies EX/MEM and MEM/WB forwarding and detects load-use hazards.
- Presents alu_op, operand_a and operand_b to the ALU, using a valid/ready handshake on both sides.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  kill held instruction (branch redirect)
id_valid  in  1  decode offers instruction
id_ready  out  1  stage accepts instruction this cycle
id_pc  in  XLEN  instruction PC
id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source indices
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_alu_op  in  4  ALU opcode (ADD=0 ... SLTU=9)
id_src_a_pc  in  1  operand A = PC
id_src_b_imm  in  1  operand B = immediate
id_rd_addr  in  REG_ADDR_W  destination
id_reg_write  in  1  writes rd
exm_reg_write, exm_is_load  in  1  EX/MEM producer info
exm_rd_addr  in  REG_ADDR_W
exm_result  in  XLEN
wb_reg_write  in  1
wb_rd_addr  in  REG_ADDR_W
wb_result  in  XLEN
ex_valid  out  1  issued instruction valid to ALU
ex_ready  in  1  downstream accepts
ex_alu_op  out  4
ex_operand_a, ex_operand_b  out  XLEN
ex_pc  out  XLEN
ex_rd_addr  out  REG_ADDR_W
ex_reg_write  out  1
stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset: clk/rst only, asynchronous active-high. All registered fields clear to 0 (valid_q, alu_op, pc, rs data, imm, rd, reg_write, select bits); stall_cycles clears to 0.
- Single-entry register. occupied = valid_q.
- hazard = valid_q && exm_reg_write && exm_is_load && exm_rd_addr!=0 && (exm_rd_addr==rs1_q || exm_rd_addr==rs2_q).
- ex_valid = valid_q && !hazard.
- ex_reg_write = reg_write_q && ex_valid.
- issue = ex_valid && ex_ready.
- id_ready = !valid_q || issue (combinational, no skid).
- Capture on id_valid && id_ready: all id_* fields registered and valid_q<=1. Latency is 1 cycle from acceptance to ex_valid when there is no hazard.
- issue without a new capture: valid_q<=0.
- flush: valid_q<=0 next edge. Overrides capture and issue; id_ready still evaluates normally, but the captured instruction is discarded.
- Forwarding (combinational on output, per source s in {rs1,rs2}):
  - Priority 1: exm_reg_write && !exm_is_load && exm_rd_addr==s_q && s_q!=0 gives exm_result.
  - Priority 2: wb_reg_write && wb_rd_addr==s_q && s_q!=0 gives wb_result.
  - Otherwise: s_data_q.
- Refresh while held: each cycle valid_q && !issue && wb_reg_write && wb_rd_addr!=0 && wb_rd_addr==s_q writes s_data_q<=wb_result. This keeps the held value correct after the producer retires.
- ex_operand_a = src_a_pc_q ? pc_q : fwd_rs1.
- ex_operand_b = src_b_imm_q ? imm_q : fwd_rs2.
- No forwarding is applied to PC or immediate paths.
- Register x0 is never forwarded. Its data is whatever decode supplied (0 from regfile).
- Outputs are stable while ex_valid && !ex_ready, except under the hazard-to-forward transition and while wb refresh changes an operand that is not yet issued.
- Reset mid-stall: all state cleared immediately; no instruction issued.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined: 32-bit stall_cycles increments by 1 every cycle valid_q && !issue && !flush (covers hazard or ex_ready low). It wraps modulo 2^32 and is cleared only by rst.
- Undefined: stall_cycles tied to 0; no counter logic.

Test Plan:
- ADD rs1=x1 (data 5), rs2=x2 (data 7), ex_ready=1, no producers -> next cycle ex_valid=1, ex_alu_op=0, operand_a=5, operand_b=7; id_ready stays 1 for back-to-back issue.
- Held instruction rs1=x3, exm_reg_write=1, exm_rd_addr=3, exm_result=0x10 and wb_rd_addr=3, wb_result=0x20 -> operand_a=0x10 (EX/MEM priority); the same case with exm_rd_addr=0 -> operand_a=0x20.
- Load-use: exm_is_load=1, exm_rd_addr=4, held rs2=x4 -> ex_valid=0, id_ready=0 for that cycle. Next cycle wb_rd_addr=4, wb_result=0xABCD -> ex_valid=1, operand_b=0xABCD.
- ex_ready=0 for 3 cycles with valid instruction -> outputs held and id_ready=0. With ID_EX_STALL_CNT_EN, stall_cycles=3. Then ex_ready=1 issues exactly once.
- flush asserted with a held instruction and a simultaneous id_valid -> next cycle ex_valid=0; the new instruction is not captured.
- rst asserted asynchronously mid-stall -> ex_valid=0, all outputs 0, stall_cycles=0 immediately, without waiting for a clk edge.
